// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the divided-clock controller
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int MIN_HALF  = 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter and toggle datapath for clk_div_ctrl
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  output logic             clk_out,
  output logic             tick,
  output logic             boundary
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             toggle;

  // half_q never drops below 1, so cnt_q < half_q and the compare cannot wrap
  assign toggle   = run && (cnt_q == (half_q - ONE));
  assign boundary = toggle && clk_out_q;

  always_comb begin
    half_d    = half_q;
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (load) begin
      half_d = half;
    end
    if (run) begin
      if (toggle) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end else begin
        cnt_d     = cnt_q + ONE;
        clk_out_d = clk_out_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      half_q    <= CNT_W'(DEF_HALF);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - glitch-free run/stop and ratio controller for the divided clock
// Optional period counter output enabled by CLK_DIV_CTRL_PCNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_PCNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept, zero_half, boundary, run, load;
  logic [CNT_W-1:0] load_half;

  assign accept    = cfg_valid && cfg_ready_q;
  assign zero_half = cfg_half < CNT_W'(MIN_HALF);
  assign run       = (state_q != ST_STOP);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    load        = 1'b0;
    load_half   = cfg_half;
    cfg_err_d   = accept && zero_half;
    case (state_q)
      ST_STOP: begin
        if (en) state_d = ST_RUN;
        // a value caught on the final boundary of a drain is applied here
        if (pend_q) begin
          load      = 1'b1;
          load_half = pend_half_q;
          pend_d    = 1'b0;
        end else if (accept && !zero_half) begin
          load = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en) state_d = ST_RUN;
        else if (boundary) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
    if (run) begin
      if (boundary && pend_q) begin
        load      = 1'b1;
        load_half = pend_half_q;
        pend_d    = 1'b0;
      end
      if (accept && !zero_half) begin
        pend_d      = 1'b1;
        pend_half_d = cfg_half;
      end
    end
    cfg_ready_d = ~pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      pend_q      <= 1'b0;
      pend_half_q <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_half_q <= pend_half_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  clk_div_core #(
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (load),
    .half     (load_half),
    .clk_out  (clk_out),
    .tick     (tick),
    .boundary (boundary)
  );

`ifdef CLK_DIV_CTRL_PCNT_EN
  logic [31:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (boundary) period_cnt_d = period_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_cnt_q <= '0;
    else        period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`endif

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = pend_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - scoreboard bench for clk_div_ctrl against a period-position model
module tb_clk_div_ctrl;

  localparam int S_STOP  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_half = '0;
  logic        cfg_ready, cfg_err, clk_out, tick, busy;
  logic [31:0] pcnt_act;

  always #5 clk = ~clk;

  clk_div_ctrl #(.CNT_W(16), .DEF_HALF(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    .period_cnt(pcnt_act)
`endif
  );

`ifndef CLK_DIV_CTRL_PCNT_EN
  assign pcnt_act = '0;
`endif

  typedef struct packed {
    logic        clk_out;
    logic        tick;
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] pcnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: position within the current period, clk_out high in the second half
  int          m_state, m_half, m_pend, m_pend_half, m_pos;
  logic [31:0] m_pcnt;
  bit          cur_en;

  function automatic bit outputs_match(exp_t x);
`ifdef CLK_DIV_CTRL_PCNT_EN
    return ({clk_out, tick, cfg_ready, cfg_err, busy} == {x.clk_out, x.tick, x.ready, x.err, x.busy})
           && (pcnt_act == x.pcnt);
`else
    return {clk_out, tick, cfg_ready, cfg_err, busy} == {x.clk_out, x.tick, x.ready, x.err, x.busy};
`endif
  endfunction

  task automatic compare(input string name, input exp_t x);
    checks++;
    if (!outputs_match(x)) begin
      failures++;
      $display("FAIL %s t=%0t clk_out/tick/ready/err/busy got=%b%b%b%b%b want=%b%b%b%b%b pcnt got=%0d want=%0d",
               name, $time, clk_out, tick, cfg_ready, cfg_err, busy,
               x.clk_out, x.tick, x.ready, x.err, x.busy, pcnt_act, x.pcnt);
    end
  endtask

  task automatic model_reset();
    exp_t x;
    m_state = S_STOP; m_half = 8; m_pend = 0; m_pend_half = 0; m_pos = 0; m_pcnt = '0;
    x = '{clk_out: 1'b0, tick: 1'b0, ready: 1'b1, err: 1'b0, busy: 1'b0, pcnt: 32'd0};
    q.push_back(x);
  endtask

  task automatic do_reset();
    exp_t x;
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cur_en = 1'b0;
    #1;
    x = '{clk_out: 1'b0, tick: 1'b0, ready: 1'b1, err: 1'b0, busy: 1'b0, pcnt: 32'd0};
    compare("async_reset", x);
    model_reset();
  endtask

  task automatic step(input bit e, input bit v, input int h);
    exp_t x;
    bit running, accept, bnd;
    int old_half, new_pos;
    @(negedge clk);
    rst_n = 1'b1; en = e; cfg_valid = v; cfg_half = 16'(h); cur_en = e;
    running  = (m_state != S_STOP);
    accept   = v && (m_pend == 0);
    bnd      = running && (m_pos == 2 * m_half - 1);
    old_half = m_half;
    new_pos  = (running && !bnd) ? m_pos + 1 : 0;
    if (!running) begin
      if (m_pend != 0) begin m_half = m_pend_half; m_pend = 0; end
      else if (accept && h != 0) m_half = h;
    end else begin
      if (bnd && m_pend != 0) begin m_half = m_pend_half; m_pend = 0; end
      if (accept && h != 0) begin m_pend = 1; m_pend_half = h; end
    end
    case (m_state)
      S_STOP:  if (e) m_state = S_RUN;
      S_RUN:   if (!e) m_state = S_DRAIN;
      default: if (e) m_state = S_RUN; else if (bnd) m_state = S_STOP;
    endcase
    m_pos = new_pos;
    if (bnd) m_pcnt = m_pcnt + 32'd1;
    x.clk_out = running && (new_pos >= old_half);
    x.tick    = running && (new_pos == old_half);
    x.err     = accept && (h == 0);
    x.ready   = (m_pend == 0);
    x.busy    = (m_pend != 0);
    x.pcnt    = m_pcnt;
    q.push_back(x);
  endtask

  task automatic run_until_pos(input int p);
    for (int i = 0; i < 200 && m_pos != p; i++) step(1'b1, 1'b0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        compare("cycle", x);
      end
    end
  end

  initial begin : stimulus
    exp_t x;
    do_reset();
    do_reset();
    repeat (40) step(1'b1, 1'b0, 0);
    run_until_pos(2);
    step(1'b1, 1'b1, 3);
    repeat (40) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    repeat (20) step(1'b1, 1'b0, 0);
    run_until_pos(m_half);
    step(1'b0, 1'b0, 0);
    repeat (10) step(1'b1, 1'b0, 0);
    run_until_pos(m_half);
    repeat (20) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1);
    repeat (12) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    repeat (2) step(1'b1, 1'b0, 0);
    do_reset();
    repeat (60) step(1'b1, 1'b0, 0);
    cur_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit e_n;
      e_n = ($urandom_range(0, 19) == 0) ? ~cur_en : cur_en;
      step(e_n, $urandom_range(0, 4) == 0, $urandom_range(0, 6));
    end
    repeat (2) step(1'b0, 1'b0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the team's divided-clock generator. It accepts a new half-period over a valid/ready handshake and starts/stops the divided clock. Ratio changes and stops take effect only on full-period boundaries, so the output never glitches and never produces a runt pulse. It sits between the register/config logic and the logic that consumes clk_out and tick.

Parameters:
CNT_W, 16, width of the half-period value and the internal counter.
DEF_HALF, 8, half-period (in clk cycles) loaded at reset. Legal range is 1..2^CNT_W-1, giving a default period of 16 clk cycles.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new half-period offered
cfg_half  input  CNT_W  offered half-period in clk cycles
cfg_ready  output  1  controller can accept cfg_half
cfg_err  output  1  one-cycle pulse when a zero half-period is accepted
clk_out  output  1  divided clock, 50% duty, period 2*half
tick  output  1  one-cycle pulse, high in the first clk cycle that clk_out is high
busy  output  1  a config is pending, waiting for a period boundary

Behaviour:
- Reset (async, rst_n=0):
  - state=STOP, cnt=0, half_reg=DEF_HALF, pend=0.
  - clk_out=0, tick=0, cfg_ready=1, cfg_err=0, busy=0.
- All outputs are registered. Handshake completes on an edge where cfg_valid&&cfg_ready. cfg_ready = !pend.
- States: STOP, RUN, DRAIN.
  - STOP -> RUN when en=1 is sampled. The first clk_out rise comes DEF_HALF/half_reg edges later.
  - RUN -> DRAIN when en=0 is sampled.
  - DRAIN -> RUN when en=1 is sampled.
  - DRAIN -> STOP at the next period boundary.
- Counting in RUN/DRAIN:
  - cnt increments each cycle.
  - When cnt==half_reg-1: cnt<=0 and clk_out toggles.
  - On a 0->1 toggle, tick=1 for that one cycle.
  - Period boundary = the 1->0 toggle.
- Config in STOP: an accepted nonzero value loads half_reg directly. pend stays 0.
- Config in RUN/DRAIN: the value is stored in pend_half and pend=1 (so busy=1, cfg_ready=0).
  - At the next period boundary: half_reg<=pend_half, pend<=0.
  - The new period starts with clk_out low for the new half value.
- Acceptance coinciding with a boundary: the value is held pending and applied at the following boundary. There is no same-edge bypass.
- Boundary coinciding with the DRAIN->STOP transition: any pending value is applied, then the block stops.
- cfg_half=0: handshake completes, the value is discarded, and cfg_err pulses one cycle. half_reg and pend are unchanged.
- cfg_half=1: clk_out toggles every clk cycle (period 2). tick is high every other cycle.
- In STOP: clk_out=0, cnt=0, tick=0.
- rst_n asserted mid-period: immediate async return to the reset values. The pending config is lost.
- cnt compare width is CNT_W. No wrap is possible because cnt < half_reg always holds.

Optional Feature:
Macro CLK_DIV_CTRL_PCNT_EN.
- Defined: adds output period_cnt (input-side none, 32 bits).
  - Increments at every period boundary and wraps at 2^32-1 -> 0.
  - Reset value 0. It holds its value in STOP.
- Undefined: the period_cnt port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package clk_div_pkg:
  - state enum (STOP, RUN, DRAIN);
  - CNT_W default constant;
  - a localparam for the minimum legal half (1).
- Natural sub-module: clk_div_core.
  - Holds the counter/toggle datapath.
  - Inputs: run, half, load strobe. Outputs: clk_out, tick, boundary.
  - clk_div_ctrl owns the FSM and the handshake.

Test Plan:
- Reset, then en=1 with default half=8: clk_out first rises 8 edges after en is sampled. Period is 16 cycles and duty 8/8. tick is high exactly 1 cycle per period.
- While running at half=8, offer cfg_half=3 mid-low-phase:
  - cfg_ready drops and busy=1;
  - the current period completes at 16 cycles;
  - the following periods are 6 cycles;
  - busy clears at the boundary.
- Offer cfg_half=0: handshake completes, cfg_err pulses once, period is unchanged, busy stays 0.
- en=0 in the middle of the high phase: clk_out completes its high phase, falls at the boundary, then stays 0. state=STOP. Reassert en during DRAIN: there is no interruption.
- In STOP, load cfg_half=1 and set en=1: clk_out alternates every cycle and tick is high every second cycle.
- Assert rst_n=0 mid-period with a config pending:
  - outputs clear immediately;
  - half_reg returns to 8 and the pending value is dropped.
  - If CLK_DIV_CTRL_PCNT_EN is defined: period_cnt=0, then it counts 1,2,3 after three boundaries.
